ucaspian_step_sched: RTL and testbench
======================================

# ucaspian_step_sched

Time-step scheduler for the uCaspian core. It accepts host commands (run N steps, clear activity, clear configuration) and sequences the axon, synapse and neuron units through them. It drives the shared `enable`, `next_step`, `clear_act` and `clear_config` controls and collects each unit's `step_done` / `clear_done`. It maintains the global time counter and returns one completion response per command.

## Interface
- `NUM_UNITS`, 3: number of sequenced units (width of done vectors).
- `SETTLE_CYC`, 2: cycles during which done inputs are ignored after `next_step` or clear assertion (covers registered, stale done flags); legal range 1..15.
- `TIMEOUT`, 65535: watchdog limit in cycles for one step or clear; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cmd_op`  in  2  0=RUN, 1=CLEAR_ACT, 2=CLEAR_CONFIG, 3=reserved
- `cmd_steps`  in  16  step count for RUN; ignored otherwise
- `cmd_vld`  in  1  command valid
- `cmd_rdy`  out  1  scheduler idle and accepting a command
- `enable`  out  1  unit enable, held for the duration of a RUN
- `next_step`  out  1  one-cycle step-start pulse to all units
- `clear_act`  out  1  level, held until all units report clear done
- `clear_config`  out  1  level, held until all units report clear done
- `unit_step_done`  in  NUM_UNITS  per-unit step complete
- `unit_clear_done`  in  NUM_UNITS  per-unit clear complete
- `step_count`  out  32  global time; number of completed steps
- `rsp_vld`  out  1  command completion valid
- `rsp_op`  out  2  op of the completed command
- `rsp_err`  out  1  1 = watchdog timeout or reserved op
- `rsp_rdy`  in  1  host accepts the response

## Operation
- States: IDLE, STEP_START, STEP_SETTLE, STEP_WAIT, CLR_SETTLE, CLR_WAIT, RESPOND.
- `cmd_rdy = (state==IDLE) && !reset`. A command is accepted on a cycle where `cmd_vld && cmd_rdy`; `cmd_op`/`cmd_steps` are latched that cycle.
- **RUN, steps=0**: go to RESPOND with `rsp_err=0`; no `next_step` is issued.
- **RUN, steps=N**: `steps_left <= N`, go to STEP_START.
  - STEP_START: `next_step=1` for exactly this cycle; go to STEP_SETTLE.
  - STEP_SETTLE: lasts SETTLE_CYC cycles; `unit_step_done` is ignored; then go to STEP_WAIT.
  - STEP_WAIT: when `&unit_step_done`, increment `step_count` and decrement `steps_left`. If the decremented value is 0, go to RESPOND; otherwise go to STEP_START.
- **CLEAR_ACT / CLEAR_CONFIG**: assert the matching clear level, go to CLR_SETTLE (SETTLE_CYC cycles), then CLR_WAIT.
  - CLR_WAIT: when `&unit_clear_done`, deassert the clear, set `step_count <= 0`, go to RESPOND.
- **Reserved op 3**: go straight to RESPOND with `rsp_err=1`.
- `enable` is high in all states from RUN acceptance until leaving STEP_WAIT for RESPOND; it is low otherwise, including during clears.
- **Watchdog**: counts cycles in STEP_WAIT or CLR_WAIT and resets on entry. On reaching TIMEOUT (when nonzero):
  - drop `enable` and any clear;
  - discard the remaining steps; `step_count` does not increment for the failed step;
  - go to RESPOND with `rsp_err=1`.
- **RESPOND**: `rsp_vld=1` with `rsp_op`/`rsp_err` held stable until `rsp_rdy`; go to IDLE on the cycle after `rsp_vld && rsp_rdy`.
- `step_count` wraps from 0xFFFFFFFF to 0 with no error.

## Timing
- **Reset values**: state IDLE; `cmd_rdy=0` during reset, 1 the cycle after; `enable=next_step=clear_act=clear_config=rsp_vld=rsp_err=0`; `rsp_op=0`; `step_count=0`.
- **Reset mid-operation**: aborts immediately; all outputs take their reset values the following cycle; no response is issued.
- All outputs are driven from registers or decoded from the registered state; no combinational path from inputs to outputs except `cmd_rdy` from `reset`.
- **RUN accepted at cycle 0**: `enable` and `next_step` are high at cycle 1; STEP_WAIT begins at cycle 2+SETTLE_CYC.
- **Step completion**: done sampled high at cycle W gives `step_count+1` and the next `next_step` at W+1. Minimum step period is 2+SETTLE_CYC cycles.
- **Final step**: `rsp_vld` rises at W+1.
- **Clear accepted at cycle 0**: the clear level is high from cycle 1 and falls the cycle after done is sampled in CLR_WAIT. `rsp_vld` rises in that same cycle.
- **Simultaneous watchdog expiry and done**: done wins; the step or clear completes normally.

## Test plan
- **RUN 3**, `SETTLE_CYC=2`, units assert done 1 cycle after `next_step`: exactly 3 `next_step` pulses spaced 4 cycles apart; `step_count` 0→3; one response `rsp_op=0`, `rsp_err=0`.
- **RUN 0**: no `next_step`, `enable` stays 0, response the cycle after acceptance; `step_count` unchanged.
- **CLEAR_CONFIG after RUN 5**: `clear_config` held until all `unit_clear_done` are high (one unit delayed 300 cycles); then `step_count=0` and response `rsp_op=2`.
- **Watchdog**, `TIMEOUT=50`, one unit never asserts `step_done` on step 2 of RUN 4: `rsp_err=1`, `step_count=1`, `enable` drops, no further `next_step`.
- **Backpressure**: hold `rsp_rdy=0` for 10 cycles: `rsp_vld`/`rsp_op`/`rsp_err` stable and `cmd_rdy=0` throughout; IDLE one cycle after the handshake.
- **Reset in STEP_WAIT during RUN 10**: all outputs at reset values the next cycle; no response; `cmd_rdy=1` after reset deasserts; reserved op 3 then returns `rsp_err=1`.

Source files
------------

// File: rtl/ucaspian_step_sched.sv
// Time-step scheduler: sequences RUN/CLEAR commands across the units; next_step 1 cycle after accept, step period 2+SETTLE_CYC.
// Backpressure: cmd_rdy only in IDLE; the response is held until rsp_rdy, with IDLE following the handshake.
module ucaspian_step_sched #(
  parameter int NUM_UNITS  = 3,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cmd_op,
  input  logic [15:0]          cmd_steps,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic                 enable,
  output logic                 next_step,
  output logic                 clear_act,
  output logic                 clear_config,
  input  logic [NUM_UNITS-1:0] unit_step_done,
  input  logic [NUM_UNITS-1:0] unit_clear_done,
  output logic [31:0]          step_count,
  output logic                 rsp_vld,
  output logic [1:0]           rsp_op,
  output logic                 rsp_err,
  input  logic                 rsp_rdy
);

  typedef enum logic [2:0] {
    IDLE, STEP_START, STEP_SETTLE, STEP_WAIT, CLR_SETTLE, CLR_WAIT, RESPOND
  } state_t;

  localparam logic [1:0]  OP_RUN      = 2'd0;
  localparam logic [1:0]  OP_CLR_ACT  = 2'd1;
  localparam logic [1:0]  OP_CLR_CFG  = 2'd2;
  localparam logic [1:0]  OP_RSVD     = 2'd3;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [31:0] WD_LAST     = 32'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [1:0]  op_q;
  logic [15:0] steps_left;
  logic [3:0]  settle_cnt;
  logic [31:0] wd_cnt;
  logic        wd_expired, step_ok, clr_ok, accept;

  assign accept     = (state == IDLE) && cmd_vld;
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign step_ok    = (state == STEP_WAIT) && (&unit_step_done);
  assign clr_ok     = (state == CLR_WAIT) && (&unit_clear_done);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (cmd_vld) begin
          case (cmd_op)
            OP_RUN:                 state_d = (cmd_steps == 16'd0) ? RESPOND : STEP_START;
            OP_CLR_ACT, OP_CLR_CFG: state_d = CLR_SETTLE;
            default:                state_d = RESPOND;
          endcase
        end
      end
      STEP_START:  state_d = STEP_SETTLE;
      STEP_SETTLE: if (settle_cnt == 4'd0) state_d = STEP_WAIT;
      // Done takes priority over a watchdog expiry in the same cycle.
      STEP_WAIT: begin
        if (&unit_step_done)  state_d = (steps_left == 16'd1) ? RESPOND : STEP_START;
        else if (wd_expired)  state_d = RESPOND;
      end
      CLR_SETTLE:  if (settle_cnt == 4'd0) state_d = CLR_WAIT;
      CLR_WAIT:    if ((&unit_clear_done) || wd_expired) state_d = RESPOND;
      RESPOND:     if (rsp_rdy) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 2'd0;
      steps_left <= 16'd0;
      settle_cnt <= 4'd0;
      wd_cnt     <= 32'd0;
      step_count <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q       <= cmd_op;
        steps_left <= cmd_steps;
        rsp_err    <= (cmd_op == OP_RSVD);
      end
      if ((state == STEP_SETTLE) || (state == CLR_SETTLE)) settle_cnt <= settle_cnt - 4'd1;
      else                                                 settle_cnt <= SETTLE_LAST;
      if ((state == STEP_WAIT) || (state == CLR_WAIT)) wd_cnt <= wd_cnt + 32'd1;
      else                                             wd_cnt <= 32'd0;
      if (step_ok) begin
        step_count <= step_count + 32'd1;
        steps_left <= steps_left - 16'd1;
      end
      if (clr_ok) step_count <= 32'd0;
      if (wd_expired && (((state == STEP_WAIT) && !(&unit_step_done)) ||
                         ((state == CLR_WAIT) && !(&unit_clear_done))))
        rsp_err <= 1'b1;
      if ((state == RESPOND) && rsp_rdy) rsp_err <= 1'b0;
    end
  end

  assign cmd_rdy      = (state == IDLE) && !reset;
  assign enable       = (state == STEP_START) || (state == STEP_SETTLE) || (state == STEP_WAIT);
  assign next_step    = (state == STEP_START);
  assign clear_act    = ((state == CLR_SETTLE) || (state == CLR_WAIT)) && (op_q == OP_CLR_ACT);
  assign clear_config = ((state == CLR_SETTLE) || (state == CLR_WAIT)) && (op_q == OP_CLR_CFG);
  assign rsp_vld      = (state == RESPOND);
  assign rsp_op       = op_q;

endmodule

// File: tb/tb_ucaspian_step_sched.sv
// Directed bench for ucaspian_step_sched with behavioural unit models and a response scoreboard.
module tb_ucaspian_step_sched;

  typedef struct {
    logic [1:0]  op;
    logic        err;
    logic [31:0] cnt;
  } rsp_t;

  logic        clk, reset;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_steps;
  logic        cmd_vld, cmd_rdy, enable, next_step, clear_act, clear_config;
  logic [2:0]  unit_step_done, unit_clear_done;
  logic [31:0] step_count;
  logic        rsp_vld, rsp_err, rsp_rdy;
  logic [1:0]  rsp_op;

  logic [1:0]  w_cmd_op;
  logic [15:0] w_cmd_steps;
  logic        w_cmd_vld, w_cmd_rdy, w_enable, w_next_step, w_clear_act, w_clear_config;
  logic [2:0]  w_step_done;
  logic [2:0]  w_clear_done = 3'b111;
  logic [31:0] w_step_count;
  logic        w_rsp_vld, w_rsp_err, w_rsp_rdy;
  logic [1:0]  w_rsp_op;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc, rsp_cyc;
  bit   last_clr;
  int   step_dly[3], clr_dly[3], scnt[3], ccnt[3];
  bit   clr_seen[3];
  bit   stall_step;
  int   w_pulses, w_cnt;
  int   ns_q[$];
  rsp_t sb[$];
  logic [31:0] exp_cnt;

  ucaspian_step_sched u_dut (
    .clk(clk), .reset(reset), .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .enable(enable), .next_step(next_step), .clear_act(clear_act),
    .clear_config(clear_config), .unit_step_done(unit_step_done), .unit_clear_done(unit_clear_done),
    .step_count(step_count), .rsp_vld(rsp_vld), .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_rdy(rsp_rdy)
  );

  ucaspian_step_sched #(.NUM_UNITS(3), .SETTLE_CYC(2), .TIMEOUT(50)) u_wd (
    .clk(clk), .reset(reset), .cmd_op(w_cmd_op), .cmd_steps(w_cmd_steps), .cmd_vld(w_cmd_vld),
    .cmd_rdy(w_cmd_rdy), .enable(w_enable), .next_step(w_next_step), .clear_act(w_clear_act),
    .clear_config(w_clear_config), .unit_step_done(w_step_done), .unit_clear_done(w_clear_done),
    .step_count(w_step_count), .rsp_vld(w_rsp_vld), .rsp_op(w_rsp_op), .rsp_err(w_rsp_err),
    .rsp_rdy(w_rsp_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Units: step done rises step_dly cycles after next_step, clear done clr_dly cycles after clear rises.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 3; u++) begin
      if (reset || next_step) begin
        unit_step_done[u] = 1'b0;
        scnt[u] = reset ? 0 : step_dly[u];
      end else if (scnt[u] > 0) begin
        scnt[u]--;
        if (scnt[u] == 0 && !stall_step) unit_step_done[u] = 1'b1;
      end
      if (!(clear_act || clear_config)) begin
        unit_clear_done[u] = 1'b0;
        clr_seen[u] = 1'b0;
        ccnt[u] = 0;
      end else if (!clr_seen[u]) begin
        clr_seen[u] = 1'b1;
        ccnt[u] = clr_dly[u];
      end else if (ccnt[u] > 0) begin
        ccnt[u]--;
        if (ccnt[u] == 0) unit_clear_done[u] = 1'b1;
      end
    end
    if (next_step) ns_q.push_back(cyc);
  end

  // Watchdog-instance units: unit 2 never finishes the second step.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      w_pulses = 0;
      w_cnt = 0;
      w_step_done = 3'b000;
    end else if (w_next_step) begin
      w_pulses++;
      w_step_done = 3'b000;
      w_cnt = 1;
    end else if (w_cnt > 0) begin
      w_cnt--;
      if (w_cnt == 0) w_step_done = (w_pulses == 2) ? 3'b011 : 3'b111;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d required completion", cyc);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] steps, input bit track);
    rsp_t e;
    chk("cmd_rdy_before_send", cmd_rdy, 1'b1);
    cmd_op = op;
    cmd_steps = steps;
    cmd_vld = 1'b1;
    acc_cyc = cyc;
    ns_q.delete();
    if (track) begin
      if (op == 2'd0) exp_cnt = exp_cnt + 32'(steps);
      else if (op != 2'd3) exp_cnt = 32'd0;
      e.op = op;
      e.err = (op == 2'd3);
      e.cnt = exp_cnt;
      sb.push_back(e);
    end
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget, input int hold);
    rsp_t e;
    int n = 0;
    bit prev = 1'b0;
    while (!rsp_vld && n < budget) begin
      prev = clear_act || clear_config;
      tick();
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp_vld, 1'b1);
    rsp_cyc = cyc;
    last_clr = prev;
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.op = 2'd0; e.err = 1'b0; e.cnt = 32'd0;
    end
    chk({tag, "_rsp_op"}, rsp_op, e.op);
    chk({tag, "_rsp_err"}, rsp_err, e.err);
    chk({tag, "_step_count"}, step_count, e.cnt);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_vld"}, rsp_vld, 1'b1);
      chk({tag, "_hold_op"}, rsp_op, e.op);
      chk({tag, "_hold_err"}, rsp_err, e.err);
      chk({tag, "_hold_cmd_rdy"}, cmd_rdy, 1'b0);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk({tag, "_idle_cmd_rdy"}, cmd_rdy, 1'b1);
    chk({tag, "_idle_rsp_vld"}, rsp_vld, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cmd_op = 2'd0; cmd_steps = 16'd0; cmd_vld = 1'b0; rsp_rdy = 1'b0;
    w_cmd_op = 2'd0; w_cmd_steps = 16'd0; w_cmd_vld = 1'b0; w_rsp_rdy = 1'b0;
    unit_step_done = 3'b000; unit_clear_done = 3'b000;
    stall_step = 1'b0;
    exp_cnt = 32'd0;
    for (int u = 0; u < 3; u++) begin
      step_dly[u] = 1; clr_dly[u] = 2; scnt[u] = 0; ccnt[u] = 0; clr_seen[u] = 1'b0;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_rdy_in_reset", cmd_rdy, 1'b0);
    reset = 1'b0;
    chk("rst_enable", enable, 1'b0);
    chk("rst_next_step", next_step, 1'b0);
    chk("rst_clear", {clear_act, clear_config}, 2'b00);
    chk("rst_rsp", {rsp_vld, rsp_err, rsp_op}, 4'b0000);
    chk("rst_step_count", step_count, 32'd0);
    tick();
    chk("rst_cmd_rdy_after", cmd_rdy, 1'b1);

    // RUN 3: pulses spaced 2+SETTLE_CYC apart
    send_cmd(2'd0, 16'd3, 1'b1);
    chk("run3_enable_c1", enable, 1'b1);
    chk("run3_next_step_c1", next_step, 1'b1);
    wait_rsp("run3", 200, 0);
    chk("run3_pulses", ns_q.size(), 3);
    chk("run3_first_pulse", (ns_q.size() > 0) ? ns_q[0] - acc_cyc : -1, 1);
    chk("run3_gap1", (ns_q.size() > 1) ? ns_q[1] - ns_q[0] : 0, 4);
    chk("run3_gap2", (ns_q.size() > 2) ? ns_q[2] - ns_q[1] : 0, 4);
    chk("run3_rsp_latency", rsp_cyc - acc_cyc, 13);

    // RUN 0: immediate response, no step
    send_cmd(2'd0, 16'd0, 1'b1);
    chk("run0_enable", enable, 1'b0);
    chk("run0_rsp_next_cycle", rsp_vld, 1'b1);
    wait_rsp("run0", 10, 0);
    chk("run0_pulses", ns_q.size(), 0);

    // CLEAR_ACT with quick units
    send_cmd(2'd1, 16'd0, 1'b1);
    chk("clract_level", {clear_act, clear_config, enable}, 3'b100);
    wait_rsp("clract", 100, 0);
    chk("clract_was_high", last_clr, 1'b1);
    chk("clract_latency", rsp_cyc - acc_cyc, 4);

    // RUN 5 then CLEAR_CONFIG with one slow unit
    send_cmd(2'd0, 16'd5, 1'b1);
    wait_rsp("run5", 300, 0);
    chk("run5_pulses", ns_q.size(), 5);
    clr_dly[1] = 300; clr_dly[0] = 1; clr_dly[2] = 1;
    send_cmd(2'd2, 16'd0, 1'b1);
    chk("clrcfg_level", {clear_act, clear_config}, 2'b01);
    repeat (250) tick();
    chk("clrcfg_held", clear_config, 1'b1);
    chk("clrcfg_no_rsp_yet", rsp_vld, 1'b0);
    wait_rsp("clrcfg", 1000, 0);
    chk("clrcfg_was_high", last_clr, 1'b1);
    chk("clrcfg_dropped", clear_config, 1'b0);
    chk("clrcfg_latency", rsp_cyc - acc_cyc, 302);

    // Backpressure on the response
    send_cmd(2'd0, 16'd2, 1'b1);
    wait_rsp("bp", 200, 10);

    // Reset while waiting in STEP_WAIT
    stall_step = 1'b1;
    send_cmd(2'd0, 16'd10, 1'b0);
    repeat (8) tick();
    chk("rstmid_enable_before", enable, 1'b1);
    chk("rstmid_count_before", step_count, exp_cnt);
    reset = 1'b1;
    tick();
    chk("rstmid_cmd_rdy", cmd_rdy, 1'b0);
    chk("rstmid_ctrl", {enable, next_step, clear_act, clear_config}, 4'b0000);
    chk("rstmid_rsp", {rsp_vld, rsp_err, rsp_op}, 4'b0000);
    chk("rstmid_step_count", step_count, 32'd0);
    reset = 1'b0;
    exp_cnt = 32'd0;
    stall_step = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_vld || !cmd_rdy) n++;
    end
    chk("rstmid_idle_no_rsp", n, 0);
    send_cmd(2'd3, 16'd0, 1'b1);
    chk("rsvd_rsp_next_cycle", rsp_vld, 1'b1);
    wait_rsp("rsvd", 10, 0);

    // Watchdog on the TIMEOUT=50 instance
    chk("wd_cmd_rdy", w_cmd_rdy, 1'b1);
    w_cmd_op = 2'd0; w_cmd_steps = 16'd4; w_cmd_vld = 1'b1;
    tick();
    w_cmd_vld = 1'b0;
    n = 0;
    while (!w_rsp_vld && n < 1000) begin
      tick();
      n++;
    end
    chk("wd_rsp_seen", w_rsp_vld, 1'b1);
    chk("wd_rsp_err", w_rsp_err, 1'b1);
    chk("wd_rsp_op", w_rsp_op, 2'd0);
    chk("wd_step_count", w_step_count, 32'd1);
    chk("wd_enable_dropped", w_enable, 1'b0);
    repeat (10) tick();
    w_rsp_rdy = 1'b1;
    tick();
    w_rsp_rdy = 1'b0;
    repeat (10) tick();
    chk("wd_pulses", w_pulses, 2);
    chk("wd_idle", {w_cmd_rdy, w_rsp_vld, w_rsp_err}, 3'b100);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
